dff_bank_checker: RTL and testbench
===================================

# dff_bank_checker

Sequencer and checker for a 64-lane bank of CC_DFF primitives held at a constant clock. It drives the bank's shared `d`/`en`/`sr` inputs through a fixed 8-vector sweep and compares every lane's `q` against an internal behavioural model. The model is derived from each lane's configuration index. The block sits beside the DFF bank in on-chip verification designs and reports pass/fail with the first failing lane and vector.

## Interface
- `SETTLE`, default 2: extra cycles each vector is held before the check cycle; legal range 2..15.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `d`, `en`, `sr`  out  1 each  registered stimulus to all bank lanes.
- `q_in`  in  64  bank outputs; asynchronous to `clk`, synchronised internally by 2 flops.
- `busy`  out  1  high from the start edge until `done`.
- `done`  out  1  one-cycle pulse when the sweep ends.
- `pass`  out  1  sweep result; valid from `done`, held until the next accepted `start`.
- `fail_idx`  out  6  lane of the first mismatch.
- `fail_vec`  out  3  vector of the first mismatch.

## Operation
- Lane k = 2*i + j, with i = k[5:1] as the config index:
  - i[0] CLK_INV, i[1] EN_INV, i[2] SR_INV, i[3] SR_VAL, i[4] INIT.
  - j = k[0] is the tied clock level.
- Model per lane:
  - On `start`, m[k] = i[4].
  - When vector v is applied, if (sr ^ i[2]) then m[k] = i[3]; otherwise m[k] holds.
  - `d`, `en`, CLK_INV and j never affect the expected value, because no clock edge ever occurs.
- Vector v = 0..7 is applied in ascending order as {sr, en, d} = v[2:0].
- FSM states:
  - IDLE: `start` → DRIVE, with v = 0.
  - DRIVE: holds vector v; the counter is loaded with SETTLE+1 and decrements each cycle; reaching 0 → CHECK.
  - CHECK: compares the synchronised `q_in` against m.
    - On mismatch without ERRLOG, or after checking v = 7 → DONE.
    - Otherwise v++ → DRIVE.
  - DONE: one cycle; `done` = 1, `busy` = 0 on exit → IDLE.
- First mismatch: latches the lowest mismatching lane into `fail_idx` and v into `fail_vec`, and sets `pass` = 0. `pass` = 1 only if no mismatch occurred in the whole sweep.
- `start` while `busy` is ignored. Holding `start` high after `done` begins a new sweep on the IDLE cycle.
- The next vector's stimulus is registered at the edge leaving CHECK.

## Timing
- Reset values (asynchronous, effective immediately): `d` = `en` = `sr` = 0, `busy` = `done` = `pass` = 0, `fail_idx` = 0, `fail_vec` = 0, `err_cnt` = 0. FSM goes to IDLE and the synchroniser is cleared.
- Cycle 0 is the edge where `start` is sampled. From then, vector v is driven during cycles v*(SETTLE+2)+1 .. (v+1)*(SETTLE+2), and its check happens in the last of those cycles.
- `done` is high in cycle 8*(SETTLE+2)+1, which is 33 for SETTLE = 2.
- The 2-flop synchroniser means the check compares `q` settled at least SETTLE-1 cycles after the stimulus edge.
- Reset asserted mid-sweep aborts the sweep without a `done` pulse; `pass` reads 0.

## Configuration
- `DFF_CHK_ERRLOG_EN` defined:
  - Adds output `err_cnt [15:0]`, which sums the mismatching lanes of every check and saturates at 16'hFFFF.
  - The sweep always runs all 8 vectors, and `fail_idx`/`fail_vec` still record the first failure.
- `DFF_CHK_ERRLOG_EN` undefined:
  - No `err_cnt` port.
  - The sweep aborts to DONE on the first mismatching check.

## Structure
- Package `dff_chk_pkg`:
  - state enum (IDLE, DRIVE, CHECK, DONE);
  - `NUM_LANES` = 64, `NUM_VEC` = 8;
  - lane-config field bit positions;
  - function `lane_cfg(k)` returning the 5-bit config index.
- Sub-module `dff_chk_model`: the 64-lane expected-value register array. Inputs are init, apply strobe and `sr`; output is the 64-bit expected vector.
- The top level holds the FSM, counters, synchroniser, compare, lowest-index priority encoder and error logging.

## Test plan
- Ideal bank model in the bench, SETTLE = 2, pulse `start` → `done` at cycle 33, `pass` = 1, `err_cnt` = 0.
- Lane 17 stuck at 0 (config i = 8, so expected 1 once `sr` = 1), ERRLOG off → check of v = 4 at cycle 20, `done` at 21, `pass` = 0, `fail_idx` = 17, `fail_vec` = 4.
- Same fault, ERRLOG on → `done` at 33, `err_cnt` = 4, `fail_idx` = 17, `fail_vec` = 4.
- Lane 24 stuck at 0 (config i = 12: SR_INV = 1, SR_VAL = 1, so expected 1 from v = 0) plus lane 40 stuck at 1 → `fail_idx` = 24, `fail_vec` = 0.
- `start` re-pulsed at cycle 10 → ignored, `done` still at 33. `start` held high through `done` → a second sweep starts, with `busy` high again the cycle after IDLE.
- `rst_n` low at cycle 10 for 2 cycles → outputs at reset values at once and no `done` pulse; a fresh `start` completes normally in 33 cycles.

Source files
------------

// File: rtl/dff_chk_pkg.sv
// dff_chk_pkg: shared types and constants for the DFF-bank checker.
//   - FSM state enum (IDLE, DRIVE, CHECK, DONE)
//   - bank geometry (NUM_LANES lanes, NUM_VEC stimulus vectors)
//   - bit positions of the per-lane configuration fields
//   - lane_cfg(k): 5-bit configuration index of lane k (lane k = 2*i + j)
//   - lane_field(k, pos): one configuration bit of lane k
// Optional feature macro used elsewhere in the slice: DFF_CHK_ERRLOG_EN.
package dff_chk_pkg;

    localparam int NUM_LANES = 64;
    localparam int NUM_VEC   = 8;
    localparam int LANE_W    = 6;
    localparam int VEC_W     = 3;
    localparam int CFG_W     = 5;

    localparam logic [2:0] CFG_CLK_INV = 3'd0;
    localparam logic [2:0] CFG_EN_INV  = 3'd1;
    localparam logic [2:0] CFG_SR_INV  = 3'd2;
    localparam logic [2:0] CFG_SR_VAL  = 3'd3;
    localparam logic [2:0] CFG_INIT    = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    // The lowest lane bit is the tied clock level; the rest is the config index.
    function automatic logic [CFG_W-1:0] lane_cfg(input logic [LANE_W-1:0] k);
        return k[LANE_W-1:1];
    endfunction

    function automatic logic lane_field(input logic [LANE_W-1:0] k, input logic [2:0] pos);
        logic [CFG_W-1:0] cfg;
        cfg = lane_cfg(k);
        return cfg[pos];
    endfunction

endpackage

// File: rtl/dff_chk_model.sv
// dff_chk_model: expected-value register array for the 64-lane DFF bank.
// No clock edge ever reaches the bank, so each lane only reacts to its
// set/reset input: it starts at INIT and is forced to SR_VAL whenever the
// shared sr input, after the lane's SR_INV, is active.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   init_i       load every lane with its INIT value (sweep start)
//   apply_i      apply the currently driven sr to every lane
//   sr_i         currently driven shared sr level
//   exp_o        expected q of every lane
module dff_chk_model
    import dff_chk_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_i,
    input  logic                 apply_i,
    input  logic                 sr_i,
    output logic [NUM_LANES-1:0] exp_o
);

    logic [NUM_LANES-1:0] exp_q;
    logic [NUM_LANES-1:0] exp_d;

    always_comb begin
        exp_d = exp_q;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (init_i) begin
                exp_d[k] = lane_field(6'(k), CFG_INIT);
            end else if (apply_i && (sr_i ^ lane_field(6'(k), CFG_SR_INV))) begin
                exp_d[k] = lane_field(6'(k), CFG_SR_VAL);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= '0;
        end else begin
            exp_q <= exp_d;
        end
    end

    assign exp_o = exp_q;

endmodule

// File: rtl/dff_bank_checker.sv
// dff_bank_checker: sequencer and checker for a 64-lane CC_DFF bank held at
// a constant clock. Sweeps {sr, en, d} through vectors 0..7, holds each for
// SETTLE+1 drive cycles plus one check cycle, and compares the synchronised
// bank outputs against dff_chk_model.
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   start                 begin a sweep (sampled only when idle)
//   d, en, sr             registered stimulus to all lanes
//   q_in[63:0]            bank outputs, asynchronous, 2-flop synchronised
//   busy                  sweep in progress (low in the done cycle)
//   done                  one-cycle end-of-sweep pulse
//   pass                  result, valid from done until the next start
//   fail_idx, fail_vec    lowest lane and vector of the first mismatch
//   err_cnt[15:0]         (DFF_CHK_ERRLOG_EN only) saturating mismatch count
// Macro DFF_CHK_ERRLOG_EN: when defined the sweep always runs all vectors and
// counts mismatching lanes; otherwise it stops at the first failing check.
//
// state | meaning
// IDLE  | waiting for start
// DRIVE | vector held on the bank, settle counter running
// CHECK | synchronised q compared against the model
// DONE  | one-cycle done pulse, result valid
module dff_bank_checker
    import dff_chk_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 d,
    output logic                 en,
    output logic                 sr,
    input  logic [NUM_LANES-1:0] q_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [LANE_W-1:0]    fail_idx,
    output logic [VEC_W-1:0]     fail_vec
`ifdef DFF_CHK_ERRLOG_EN
    ,
    output logic [15:0]          err_cnt
`endif
);

    localparam logic [4:0]       CNT_LOAD = 5'(SETTLE + 1);
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

    state_e               state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [VEC_W-1:0]     vec_q, vec_d;
    logic [2:0]           stim_q, stim_d;   // {sr, en, d}
    logic [NUM_LANES-1:0] sync1_q, sync2_q;
    logic                 fail_seen_q;
    logic                 pass_q;
    logic [LANE_W-1:0]    fail_idx_q;
    logic [VEC_W-1:0]     fail_vec_q;

    logic                 model_init;
    logic                 model_apply;
    logic                 end_sweep;
    logic                 abort_now;
    logic [NUM_LANES-1:0] exp_vec;
    logic [NUM_LANES-1:0] mm;
    logic                 any_mm;
    logic [LANE_W-1:0]    low_idx;

    dff_chk_model u_model (
        .clk     (clk),
        .rst_n   (rst_n),
        .init_i  (model_init),
        .apply_i (model_apply),
        .sr_i    (stim_q[2]),
        .exp_o   (exp_vec)
    );

    assign mm     = sync2_q ^ exp_vec;
    assign any_mm = |mm;

    // Descending scan so the lowest mismatching lane wins.
    always_comb begin
        low_idx = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (mm[k]) begin
                low_idx = LANE_W'(k);
            end
        end
    end

`ifdef DFF_CHK_ERRLOG_EN
    assign abort_now = 1'b0;
`else
    assign abort_now = any_mm;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vec_d       = vec_q;
        stim_d      = stim_q;
        model_init  = 1'b0;
        model_apply = 1'b0;
        end_sweep   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = DRIVE;
                    cnt_d      = CNT_LOAD;
                    vec_d      = '0;
                    stim_d     = '0;
                    model_init = 1'b1;
                end
            end
            DRIVE: begin
                // Model catches up with the new sr in the first drive cycle.
                model_apply = (cnt_q == CNT_LOAD);
                cnt_d       = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (abort_now || (vec_q == LAST_VEC)) begin
                    state_d   = DONE;
                    end_sweep = 1'b1;
                end else begin
                    state_d = DRIVE;
                    cnt_d   = CNT_LOAD;
                    vec_d   = vec_q + 3'd1;
                    stim_d  = vec_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            stim_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            stim_q  <= stim_d;
            sync1_q <= q_in;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_seen_q <= 1'b0;
            pass_q      <= 1'b0;
            fail_idx_q  <= '0;
            fail_vec_q  <= '0;
        end else if ((state_q == IDLE) && start) begin
            fail_seen_q <= 1'b0;
            pass_q      <= 1'b0;
            fail_idx_q  <= '0;
            fail_vec_q  <= '0;
        end else if (state_q == CHECK) begin
            if (any_mm && !fail_seen_q) begin
                fail_seen_q <= 1'b1;
                fail_idx_q  <= low_idx;
                fail_vec_q  <= vec_q;
            end
            if (end_sweep) begin
                pass_q <= !(fail_seen_q || any_mm);
            end
        end
    end

`ifdef DFF_CHK_ERRLOG_EN
    logic [6:0]  mm_cnt;
    logic [16:0] err_sum;
    logic [15:0] err_cnt_q;

    always_comb begin
        mm_cnt = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            mm_cnt = mm_cnt + {6'd0, mm[k]};
        end
    end

    assign err_sum = {1'b0, err_cnt_q} + {10'd0, mm_cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            err_cnt_q <= '0;
        end else if (state_q == CHECK) begin
            err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign d        = stim_q[0];
    assign en       = stim_q[1];
    assign sr       = stim_q[2];
    assign busy     = (state_q == DRIVE) || (state_q == CHECK);
    assign done     = (state_q == DONE);
    assign pass     = pass_q;
    assign fail_idx = fail_idx_q;
    assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_dff_bank_checker.sv
// Bench for dff_bank_checker: an ideal DFF bank with injectable stuck-at
// faults drives q_in; a sweep-level reference (vector timeline plus a
// per-sweep outcome computed from the lane rules) is compared against the
// DUT on every cycle. Honours DFF_CHK_ERRLOG_EN like the design.
module tb_dff_bank_checker;

    localparam int SETTLE   = 2;
    localparam int PER      = SETTLE + 2;
    localparam int FULL_END = 8 * PER + 1;
`ifdef DFF_CHK_ERRLOG_EN
    localparam bit ERRLOG = 1'b1;
`else
    localparam bit ERRLOG = 1'b0;
`endif

    typedef struct packed {
        logic        ok;
        logic [5:0]  idx;
        logic [2:0]  vec;
        logic [31:0] err;
        logic [31:0] pend;
    } plan_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        d, en, sr, busy, done, pass;
    logic [63:0] q_in;
    logic [5:0]  fail_idx;
    logic [2:0]  fail_vec;
`ifdef DFF_CHK_ERRLOG_EN
    logic [15:0] err_cnt;
`endif

    logic [63:0] stuck0 = '0;
    logic [63:0] stuck1 = '0;
    logic [63:0] bank_hold = '0;
    logic [63:0] bank_q;
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    dff_bank_checker #(.SETTLE(SETTLE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .d        (d),
        .en       (en),
        .sr       (sr),
        .q_in     (q_in),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .fail_idx (fail_idx),
        .fail_vec (fail_vec)
`ifdef DFF_CHK_ERRLOG_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    function automatic logic [4:0] cfg_of(input int k);
        return 5'(k / 2);
    endfunction

    function automatic logic [63:0] init_vec();
        logic [63:0] r;
        logic [4:0]  c;
        for (int k = 0; k < 64; k++) begin
            c    = cfg_of(k);
            r[k] = c[4];
        end
        return r;
    endfunction

    // Whole-sweep outcome from the lane rules and the injected faults.
    function automatic plan_t make_plan(input logic [63:0] s0, input logic [63:0] s1);
        plan_t       r;
        logic [63:0] m, mm;
        logic [4:0]  c;
        logic        srv;
        bit          found;
        int          e;
        r      = '0;
        r.ok   = 1'b1;
        r.pend = FULL_END;
        found  = 0;
        e      = 0;
        m      = init_vec();
        for (int v = 0; v < 8; v++) begin
            if (!(found && !ERRLOG)) begin
                srv = (v >= 4);
                for (int k = 0; k < 64; k++) begin
                    c = cfg_of(k);
                    if (srv != c[2]) m[k] = c[3];
                end
                mm = m ^ ((m & ~s0) | s1);
                if (mm != 0) begin
                    e += $countones(mm);
                    if (!found) begin
                        found = 1;
                        r.ok  = 1'b0;
                        r.vec = 3'(v);
                        for (int k = 63; k >= 0; k--) if (mm[k]) r.idx = 6'(k);
                        if (!ERRLOG) r.pend = (v + 1) * PER + 1;
                    end
                end
            end
        end
        r.err = (e > 65535) ? 65535 : e;
        return r;
    endfunction

    plan_t plan;
    always_comb plan = make_plan(stuck0, stuck1);

    // Ideal bank: a lane follows SR_VAL while its sr is active, else holds.
    always_comb begin
        logic [4:0] c;
        bank_q = bank_hold;
        for (int k = 0; k < 64; k++) begin
            c = cfg_of(k);
            if (sr != c[2]) bank_q[k] = c[3];
        end
    end
    assign q_in = (bank_q & ~stuck0) | stuck1;

    // Sweep timeline: p is the cycle number within the sweep (1 = first drive).
    bit         sweeping;
    int         p;
    logic       h_pass;
    logic [5:0] h_idx;
    logic [2:0] h_vec;
    logic [31:0] h_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweeping <= 0;
            p        <= 0;
            h_pass   <= 1'b0;
            h_idx    <= '0;
            h_vec    <= '0;
            h_err    <= '0;
        end else if (sweeping) begin
            if (p == plan.pend) sweeping <= 0;
            else p <= p + 1;
            if (p + 1 == plan.pend) begin
                h_pass <= plan.ok;
                h_idx  <= plan.idx;
                h_vec  <= plan.vec;
                h_err  <= plan.err;
            end
        end else if (start) begin
            sweeping <= 1;
            p        <= 1;
        end
    end

    always @(posedge clk) begin
        if (rst_n && !sweeping && start) bank_hold <= init_vec();
        else bank_hold <= bank_q;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_pass", pass, 0);
            chk("rst_stim", {sr, en, d}, 0);
            chk("rst_fail_idx", fail_idx, 0);
            chk("rst_fail_vec", fail_vec, 0);
`ifdef DFF_CHK_ERRLOG_EN
            chk("rst_err_cnt", err_cnt, 0);
`endif
        end else if (sweeping) begin
            chk("busy", busy, p < plan.pend);
            chk("done", done, p == plan.pend);
            if (p < plan.pend) chk("stim", {sr, en, d}, (p - 1) / PER);
            if (p == plan.pend) begin
                chk("pass", pass, plan.ok);
                chk("fail_idx", fail_idx, plan.idx);
                chk("fail_vec", fail_vec, plan.vec);
`ifdef DFF_CHK_ERRLOG_EN
                chk("err_cnt", err_cnt, plan.err);
`endif
            end
        end else begin
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_pass", pass, h_pass);
            chk("idle_fail_idx", fail_idx, h_idx);
            chk("idle_fail_vec", fail_vec, h_vec);
`ifdef DFF_CHK_ERRLOG_EN
            chk("idle_err_cnt", err_cnt, h_err);
`endif
        end
    end

    // repulse_at < 0 leaves start untouched; > 0 pulses start in that cycle.
    task automatic wait_done(input int repulse_at, output int dp);
        int t;
        t = 0;
        while (done !== 1'b1 && t < 400) begin
            @(negedge clk);
            if (repulse_at >= 0) start = (repulse_at > 0) && sweeping && (p == repulse_at);
            t++;
        end
        if (done !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within 400 cycles");
            dp = -1;
        end else begin
            dp = p;
        end
    endtask

    task automatic sweep(input int repulse_at, output int dp);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(repulse_at, dp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int dp, t, dc;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Ideal bank.
        chk("plan_ideal_end", plan.pend, 33);
        sweep(0, dp);
        chk("ideal_done_cyc", dp, 33);
        chk("ideal_pass", pass, 1);
`ifdef DFF_CHK_ERRLOG_EN
        chk("ideal_err_cnt", err_cnt, 0);
`endif

        // Lane 17 stuck at 0.
        @(negedge clk);
        stuck0 = 64'd1 << 17;
        sweep(0, dp);
        chk("l17_done_cyc", dp, ERRLOG ? 33 : 21);
        chk("l17_pass", pass, 0);
        chk("l17_fail_idx", fail_idx, 17);
        chk("l17_fail_vec", fail_vec, 4);
`ifdef DFF_CHK_ERRLOG_EN
        chk("l17_err_cnt", err_cnt, 4);
`endif

        // Lane 24 stuck at 0, lane 40 stuck at 1.
        @(negedge clk);
        stuck0 = 64'd1 << 24;
        stuck1 = 64'd1 << 40;
        sweep(0, dp);
        chk("l24_done_cyc", dp, ERRLOG ? 33 : 5);
        chk("l24_pass", pass, 0);
        chk("l24_fail_idx", fail_idx, 24);
        chk("l24_fail_vec", fail_vec, 0);
`ifdef DFF_CHK_ERRLOG_EN
        chk("l24_err_cnt", err_cnt, 16);
`endif

        // Start re-pulsed while busy.
        @(negedge clk);
        stuck0 = '0;
        stuck1 = '0;
        sweep(10, dp);
        chk("repulse_done_cyc", dp, 33);
        chk("repulse_pass", pass, 1);

        // Start held through done: a second sweep follows the idle cycle.
        @(negedge clk);
        start = 1'b1;
        wait_done(-1, dp);
        chk("held1_done_cyc", dp, 33);
        @(negedge clk);
        chk("held_idle_busy", busy, 0);
        @(negedge clk);
        chk("held_rebusy", busy, 1);
        start = 1'b0;
        wait_done(0, dp);
        chk("held2_done_cyc", dp, 33);

        // Reset in the middle of a sweep.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!(sweeping && p == 10) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("rst_mid_reached", sweeping && p == 10, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_now_busy", busy, 0);
        chk("rst_now_pass", pass, 0);
        chk("rst_now_stim", {sr, en, d}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dc++;
        end
        chk("rst_no_done", dc, 0);
        sweep(0, dp);
        chk("post_rst_done_cyc", dp, 33);

        // Randomised faults, gaps and ignored start pulses.
        for (int it = 0; it < 12; it++) begin
            @(negedge clk);
            case ($urandom_range(0, 3))
                0: begin stuck0 = '0; stuck1 = '0; end
                1: begin stuck0 = 64'd1 << $urandom_range(0, 63); stuck1 = '0; end
                2: begin
                    stuck0 = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                    stuck1 = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom} & ~stuck0;
                end
                default: begin stuck0 = '0; stuck1 = 64'd1 << $urandom_range(0, 63); end
            endcase
            repeat ($urandom_range(0, 5)) @(negedge clk);
            sweep(($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 20)) : 0, dp);
            chk("rnd_done_cyc", dp, plan.pend);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
